// File: rtl/cs_sample_framer_if.sv
// Stream bundle between the acquisition front end, the framer and the
// measurement stage. The framer takes the slave side.
interface cs_sample_framer_if #(
  parameter int DATA_W = 4,
  parameter int ROW_W  = 6,
  parameter int COL_W  = 7
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out_stall;
  logic [DATA_W-1:0] values;
  logic              out_valid;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              frame_start;
  logic              frame_done;
  logic              overflow;

  modport master (
    output in_data, in_valid, out_stall,
    input  in_ready, values, out_valid, out_row, out_col,
           frame_start, frame_done, overflow
  );

  modport slave (
    input  in_data, in_valid, out_stall,
    output in_ready, values, out_valid, out_row, out_col,
           frame_start, frame_done, overflow
  );
endinterface

// File: rtl/cs_sample_framer.sv
// Ping-pong sample framer: one bank fills from the front end while the other
// is replayed, each sample held for N_ROWS cycles with row/col indices.
module cs_sample_framer #(
  parameter int DATA_W = 4,
  parameter int N_COLS = 96,
  parameter int N_ROWS = 48
) (
  input logic sys_clk,
  input logic sys_reset,
  cs_sample_framer_if.slave bus
);
  // state    | meaning
  // S_IDLE   | waiting for full[rd_bank]
  // S_STREAM | replaying rd_bank, one row per unstalled cycle
  // S_DONE   | frame_done pulse, release rd_bank

  localparam int ROW_W = 6;
  localparam int COL_W = 7;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_q [2][N_COLS];

  state_t            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [COL_W-1:0]  wr_idx_q, wr_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] values_q, values_d;
  logic [ROW_W-1:0]  out_row_q, out_row_d;
  logic [COL_W-1:0]  out_col_q, out_col_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic              in_ready;
  logic              wr_en;
  logic [COL_W-1:0]  col_inc;

  assign in_ready = ~full_q[wr_bank_q];
  assign wr_en    = bus.in_valid & in_ready;
  assign col_inc  = out_col_q + COL_W'(1);

  always_comb begin
    state_d       = state_q;
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    rd_bank_d     = rd_bank_q;
    values_d      = values_q;
    out_row_d     = out_row_q;
    out_col_d     = out_col_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q | (bus.in_valid & ~in_ready);

    if (wr_en) begin
      if (wr_idx_q == LAST_COL) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + COL_W'(1);
      end
    end

    // The bank cleared in S_DONE is never the bank the writer fills, so the
    // set above and the clear below cannot collide.
    unique case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d       = S_STREAM;
          values_d      = mem_q[rd_bank_q][COL_W'(0)];
          out_row_d     = '0;
          out_col_d     = '0;
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      S_STREAM: begin
        out_valid_d = 1'b1;
        if (!bus.out_stall) begin
          if (out_row_q == LAST_ROW) begin
            out_row_d = '0;
            if (out_col_q == LAST_COL) begin
              out_col_d    = '0;
              state_d      = S_DONE;
              out_valid_d  = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              out_col_d = col_inc;
              values_d  = mem_q[rd_bank_q][col_inc];
            end
          end else begin
            out_row_d = out_row_q + ROW_W'(1);
          end
        end
      end
      S_DONE: begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      state_q       <= S_IDLE;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_bank_q     <= 1'b0;
      values_q      <= '0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_bank_q     <= rd_bank_d;
      values_q      <= values_d;
      out_row_q     <= out_row_d;
      out_col_q     <= out_col_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en && sys_reset) begin
      mem_q[wr_bank_q][wr_idx_q] <= bus.in_data;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.values      = values_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_col     = out_col_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_cs_sample_framer.sv
// Scoreboard bench for cs_sample_framer: a frame-level model queues the
// expected replay; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cs_sample_framer;
  localparam int N_COLS = 96;
  localparam int N_ROWS = 48;

  typedef struct {
    logic [3:0] v;
    int         row;
    int         col;
  } ent_t;

  logic sys_clk = 1'b0;
  logic sys_reset;
  int   cyc = 0;

  cs_sample_framer_if #(.DATA_W(4)) bus ();

  cs_sample_framer #(.DATA_W(4), .N_COLS(N_COLS), .N_ROWS(N_ROWS)) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  ent_t       exp_q[$];
  int         frame_t[$];
  logic [3:0] partial[$];
  int         buffered  = 0;
  bit         model_ovf = 0;

  bit   mon_en     = 0;
  bit   prev_stall = 0;
  bit   prev_last  = 0;
  int   last_end   = -10;
  int   vcnt = 0;
  int   scnt = 0;
  ent_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Frame-level model: accepted samples fill up to two frames of storage;
  // a complete frame expands into N_COLS*N_ROWS expected output cycles.
  task automatic accept(input logic [3:0] d);
    partial.push_back(d);
    buffered++;
    if (partial.size() == N_COLS) begin
      for (int c = 0; c < N_COLS; c++)
        for (int r = 0; r < N_ROWS; r++)
          exp_q.push_back('{v: partial[c], row: r, col: c});
      frame_t.push_back(cyc);
      partial.delete();
    end
  endtask

  // Called at posedge+1: checks ready/overflow, drives one cycle of inputs.
  task automatic drive_cycle(input bit v, input logic [3:0] d, input bit st);
    bit exp_rdy;
    exp_rdy = (buffered < 2 * N_COLS);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("overflow", bus.overflow, model_ovf);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_stall = st;
    @(posedge sys_clk);
    #1;
    if (v) begin
      if (exp_rdy) accept(d);
      else model_ovf = 1;
    end
  endtask

  task automatic feed(input int n, input bit counting, input int gap_pct);
    logic [3:0] d;
    for (int k = 0; k < n; k++) begin
      d = counting ? 4'(k % 16) : 4'($urandom);
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive_cycle(0, 4'h0, 0);
      drive_cycle(1, d, 0);
    end
  endtask

  task automatic drain(input int budget, input bit stall_at, input int stall_pct);
    int  n = 0;
    int  st_left = 0;
    bit  stalled = 0;
    bit  st;
    while (exp_q.size() != 0 && n < budget) begin
      if (stall_at && !stalled && bus.out_valid === 1'b1 &&
          bus.out_col == 7'd5 && bus.out_row == 6'd20) begin
        stalled = 1;
        st_left = 10;
      end
      st = (st_left > 0) || (stall_pct > 0 && $urandom_range(99) < stall_pct);
      if (st_left > 0) st_left--;
      drive_cycle(0, 4'h0, st);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) drive_cycle(0, 4'h0, 0);
  endtask

  task automatic pulse_reset();
    bus.in_valid  = 0;
    bus.out_stall = 0;
    sys_reset     = 0;
    @(posedge sys_clk);
    #1;
    sys_reset = 1;
    exp_q.delete();
    frame_t.delete();
    partial.delete();
    buffered   = 0;
    model_ovf  = 0;
    prev_stall = 0;
    prev_last  = 0;
    last_end   = -10;
    vcnt = 0;
    scnt = 0;
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      bit exp_fd;
      bit newp;
      int t;
      int exp_start;
      exp_fd    = prev_last;
      prev_last = 0;
      chk("frame_done", bus.frame_done, exp_fd);
      if (exp_fd) begin
        buffered -= N_COLS;
        chk("frame_len", vcnt, N_COLS * N_ROWS + scnt);
      end
      if (bus.out_valid === 1'b1) begin
        newp = !prev_stall;
        if (newp) begin
          chk("exp_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          if (cur.row == 0 && cur.col == 0) begin
            vcnt = 0;
            scnt = 0;
            if (frame_t.size() != 0) begin
              t = frame_t.pop_front();
              exp_start = (t + 1 > last_end + 3) ? t + 1 : last_end + 3;
              chk("start_cycle", cyc, exp_start);
            end
          end
        end
        vcnt++;
        if (bus.out_stall === 1'b1) scnt++;
        chk("values", bus.values, cur.v);
        chk("out_row", bus.out_row, cur.row);
        chk("out_col", bus.out_col, cur.col);
        chk("frame_start", bus.frame_start, newp && cur.row == 0 && cur.col == 0);
        prev_stall = (bus.out_stall === 1'b1);
        if (!prev_stall && cur.row == N_ROWS - 1 && cur.col == N_COLS - 1) begin
          prev_last = 1;
          last_end  = cyc;
        end
      end else begin
        chk("frame_start_idle", bus.frame_start, 0);
        prev_stall = 0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    sys_reset     = 0;
    bus.in_valid  = 0;
    bus.in_data   = '0;
    bus.out_stall = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_values", bus.values, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_col", bus.out_col, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_overflow", bus.overflow, 0);
    sys_reset = 1;
    mon_en    = 1;

    // single frame of k mod 16
    feed(N_COLS, 1, 0);
    drain(6000, 0, 0);

    // ping-pong: two frames back to back
    feed(2 * N_COLS, 0, 0);
    drain(12000, 0, 0);

    // stall 10 cycles at col 5 row 20
    feed(N_COLS, 0, 20);
    drain(6000, 1, 0);

    // overflow: 300 continuous offers, sparse random stalls on replay
    feed(300, 0, 0);
    chk("overflow_sticky", bus.overflow, 1);
    drain(12000, 0, 2);
    chk("overflow_held", bus.overflow, 1);

    // reset during col 40
    feed(N_COLS, 0, 0);
    guard = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_col == 7'd40) && guard < 4000) begin
      drive_cycle(0, 4'h0, 0);
      guard++;
    end
    chk("reached_col40", bus.out_col, 40);
    pulse_reset();
    chk("post_rst_out_valid", bus.out_valid, 0);
    repeat (3000) drive_cycle(0, 4'h0, 0);

    // partial frame stays silent until completed
    feed(50, 0, 0);
    repeat (10000) drive_cycle(0, 4'h0, 0);
    chk("partial_silent", bus.out_valid, 0);
    feed(N_COLS - 50, 0, 30);
    drain(6000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cs_sample_framer.md
# cs_sample_framer

Upstream feeder for the compressed-sensing measurement stage. It collects a frame of 96 four-bit samples from the acquisition front end into a ping-pong buffer. It then replays each sample on `values`, held for 48 consecutive cycles (one cycle per measurement row), with row/column indices alongside. While one frame is being replayed, the next frame fills the other bank, so acquisition continues without gaps as long as the source is no faster than one frame per 4608 replay cycles.

## Interface
Parameters:
- `DATA_W`, 4: sample width
- `N_COLS`, 96: samples per frame (matrix columns)
- `N_ROWS`, 48: hold cycles per sample (matrix rows)

Ports:
- `sys_clk`  in  1  single clock; all logic on rising edge
- `sys_reset`  in  1  reset, synchronous, active-low
- `in_data`  in  DATA_W  sample from front end
- `in_valid`  in  1  `in_data` valid this cycle
- `in_ready`  out  1  framer can accept a sample; a sample transfers when `in_valid && in_ready`
- `out_stall`  in  1  downstream freeze request
- `values`  out  DATA_W  current sample to the measurement stage
- `out_valid`  out  1  `values` / `out_row` / `out_col` are meaningful
- `out_row`  out  6  row index 0..47 of the current cycle
- `out_col`  out  7  column index 0..95 of the current sample
- `frame_start`  out  1  one-cycle pulse on the first `out_valid` cycle of a frame
- `frame_done`  out  1  one-cycle pulse after the last row/column cycle of a frame
- `overflow`  out  1  sticky; a sample was offered while `in_ready` was low

## Operation
- **Storage:** two banks (0, 1) of N_COLS × DATA_W. Each bank has a `full` flag. Write bank pointer `wr_bank` and write index `wr_idx` (0..95).
- **Write side:**
  - `in_ready = !full[wr_bank]`, derived from registered state only.
  - On transfer: `mem[wr_bank][wr_idx] <= in_data` and `wr_idx` increments.
  - At `wr_idx == N_COLS-1`: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_idx` to 0.
- **Overflow:** `in_valid && !in_ready` drops the sample and sets `overflow`. Only reset clears `overflow`.
- **Read FSM, IDLE:** `out_valid = 0`. If `full[rd_bank]`, load `values <= mem[rd_bank][0]`, clear `out_row` and `out_col`, and go to STREAM.
- **Read FSM, STREAM:** `out_valid = 1`. Each non-stalled cycle, `out_row` increments.
  - At row N_ROWS-1: row wraps to 0, `out_col` increments, and `values` loads `mem[rd_bank][out_col+1]` in that same edge.
  - At row N_ROWS-1 and col N_COLS-1: go to DONE.
- **Read FSM, DONE:** one cycle. `out_valid = 0` and `frame_done = 1`. Clear `full[rd_bank]`, toggle `rd_bank`, return to IDLE.
- **Stall:** `out_stall` high in STREAM freezes the row/col counters, `values` and state; `out_valid` stays 1. `out_stall` is ignored in IDLE and DONE.
- **Simultaneous set/clear:** a `full` flag set by the writer and a `full` flag cleared by DONE in the same cycle always refer to different banks, so both take effect. A freed bank shows `in_ready = 1` the following cycle.
- **Arithmetic:** counters are plain unsigned values with explicit wrap compares; no arithmetic on data.
- **Reset mid-operation:** the next edge with `sys_reset` low discards partial and full frames.
  - Both `full` flags cleared; `wr_bank = rd_bank = 0`; `wr_idx = 0`; FSM to IDLE.
  - Memory contents are not cleared.

## Timing
- **Reset values:** `values = 0`, `out_valid = 0`, `out_row = 0`, `out_col = 0`, `frame_start = 0`, `frame_done = 0`, `overflow = 0`.
- **`in_ready` at reset:** `in_ready = 1` from the first cycle after reset release.
- **Start latency:** the final sample of a frame transfers at edge T, so `full` is set at T. The FSM leaves IDLE at T+1, and `out_valid` and `frame_start` are first high in the cycle after edge T+1.
- **Frame length:** exactly N_COLS × N_ROWS = 4608 `out_valid` cycles without stall, then one DONE cycle.
- **Back-to-back frames:** `out_valid` is low for a minimum of 2 cycles (DONE + IDLE).
- **Throughput:** one sample per cycle on the input while the write bank is not full.

## Test plan
- **Single frame:** after reset, feed samples k mod 16 for k=0..95, one per cycle. Then `frame_start` fires 2 cycles after the last transfer, `values` = col mod 16 for 48 cycles per col, `out_row` cycles 0..47, and `frame_done` fires after 4608 valid cycles.
- **Ping-pong fill:** stream 192 samples continuously. `in_ready` stays 1 for all 192, and the second frame replays immediately after the first, with a 2-cycle `out_valid` gap.
- **Overflow:** offer 300 samples continuously. `in_ready` drops after sample 191, `overflow` rises on the first rejected offer and stays set, and the first two frames replay intact.
- **Stall:** assert `out_stall` for 10 cycles at col 5, row 20. The outputs hold col 5, row 20, same `values`, with `out_valid` = 1. The frame completes at 4618 cycles.
- **Reset mid-frame:** pulse `sys_reset` low for 1 cycle during col 40. `out_valid` = 0 next cycle, `in_ready` = 1 after release, and no `frame_done` is issued.
- **Partial frame:** feed 50 samples, then hold `in_valid` low for 10000 cycles. `out_valid` stays 0 until 46 more samples arrive.
